// File: rtl/alu_uart_rx.sv
// -----------------------------------------------------------------------------
// alu_uart_rx
//   Receive side of the ALU UART link. Deserialises rxd_i (start bit,
//   DATA_WIDTH data bits LSB first, optional even-parity bit, one stop bit)
//   and presents each good byte on an AXI-stream master port.
//
//   Configuration macro: UART_RX_PARITY_EN
//     defined   -> an even-parity bit sits between data and stop bits and
//                  parity_error_o is operative.
//     undefined -> no parity bit; parity_error_o is tied to 0.
//
// Ports
//   clk_i            system clock
//   rst_ni           asynchronous reset, active low
//   rxd_i            serial input, asynchronous to clk_i, idles high
//   prescale_i       clk_i cycles per bit (values below 4 behave as 4)
//   m_axis_tdata_o   received byte
//   m_axis_tvalid_o  byte available
//   m_axis_tready_i  consumer accepts byte
//   busy_o           frame in progress
//   frame_error_o    1-cycle pulse: stop bit sampled low
//   overrun_error_o  1-cycle pulse: good frame finished while a byte is held
//   parity_error_o   1-cycle pulse: parity mismatch
// -----------------------------------------------------------------------------
module alu_uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rxd_i,
    input  logic [15:0]           prescale_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic                  busy_o,
    output logic                  frame_error_o,
    output logic                  overrun_error_o,
    output logic                  parity_error_o
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity: the transmitted parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] data);
        return ^data;
    endfunction
`endif

    state_t                  state_q, state_d;
    logic [1:0]              sync_q;
    logic                    prev_q;
    logic [15:0]             cnt_q, cnt_d;
    logic [15:0]             presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    busy_q, busy_d;
    logic                    ferr_q, ferr_d;
    logic                    oerr_q, oerr_d;
`ifdef UART_RX_PARITY_EN
    logic                    par_bad_q, par_bad_d;
    logic                    perr_q, perr_d;
`endif

    logic                    rxd_s;
    logic                    cnt_zero_s;
    logic                    good_s;
    logic [15:0]             presc_clamp_s;

    assign rxd_s         = sync_q[1];
    assign cnt_zero_s    = (cnt_q == 16'd0);
    assign presc_clamp_s = (prescale_i < 16'd4) ? 16'd4 : prescale_i;

    // Two-flop synchroniser plus edge-history flop; all idle high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rxd_i};
            prev_q <= rxd_s;
        end
    end

    // Frame FSM next state, bit timing, deserialisation and output slot.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        presc_d  = presc_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tdata_d  = tdata_q;
        ferr_d   = 1'b0;
        oerr_d   = 1'b0;
        good_s   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        // A completed handshake empties the slot; a new byte may refill it below.
        if (tvalid_q && m_axis_tready_i) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end

        case (state_q)
            ST_IDLE: begin
                // Only a true 1->0 transition starts a frame, so a stuck-low line never retriggers.
                if (!rxd_s && prev_q) begin
                    presc_d = presc_clamp_s;
                    cnt_d   = (presc_clamp_s >> 1) - 16'd1;
                    state_d = ST_START;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (!cnt_zero_s) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rxd_s) begin
                    state_d = ST_IDLE;      // glitch, not a start bit
                end else begin
                    cnt_d   = presc_q - 16'd1;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!cnt_zero_s) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shift_d = {rxd_s, shift_q[DATA_WIDTH-1:1]};
                    cnt_d   = presc_q - 16'd1;
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (!cnt_zero_s) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    par_bad_d = (rxd_s != even_parity(shift_q));
                    cnt_d     = presc_q - 16'd1;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (!cnt_zero_s) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    state_d = ST_IDLE;
                    if (!rxd_s) begin
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        good_s = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Slot free, or being emptied this very cycle: load. Otherwise drop and flag.
        if (good_s) begin
            if (!tvalid_q || m_axis_tready_i) begin
                tdata_d  = shift_q;
                tvalid_d = 1'b1;
            end else begin
                oerr_d = 1'b1;
            end
        end else begin
            oerr_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 16'd0;
            presc_q  <= 16'd4;
            idx_q    <= '0;
            shift_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            ferr_q   <= 1'b0;
            oerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            busy_q   <= busy_d;
            ferr_q   <= ferr_d;
            oerr_q   <= oerr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity result of the current frame and the registered parity error pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
        end
    end

    assign parity_error_o = perr_q;
`else
    assign parity_error_o = 1'b0;
`endif

    assign m_axis_tdata_o  = tdata_q;
    assign m_axis_tvalid_o = tvalid_q;
    assign busy_o          = busy_q;
    assign frame_error_o   = ferr_q;
    assign overrun_error_o = oerr_q;

endmodule
